seq_restoring_divider: RTL and testbench
========================================

// Module: seq_restoring_divider
// PURPOSE
//  Iterative radix-2 restoring divider for unsigned integers: the inverse datapath of the array multiplier.
//  Computes one quotient bit per clock using a row of full-subtractor cells with restore muxes.
//  Sits beside the multiplier in the arithmetic unit and uses a start/done handshake.
//  Produces quotient and remainder for WIDTH-bit operands.
// PARAMETERS
//  WIDTH  5  operand, quotient and remainder width in bits (>=2)
// PORTS
//  clk          in   1      single clock; all state updates on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  start        in   1      request; sampled only when busy==0
//  dividend     in   WIDTH  unsigned dividend; sampled with an accepted start
//  divisor      in   WIDTH  unsigned divisor; sampled with an accepted start
//  busy         out  1      high while an operation is in progress (LOAD/RUN)
//  done         out  1      one-cycle pulse; results are valid from this cycle
//  quotient     out  WIDTH  result quotient; holds until the next accepted start
//  remainder    out  WIDTH  result remainder; holds until the next accepted start
//  div_by_zero  out  1      set with done when divisor==0; holds like the results
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; busy, done, div_by_zero=0; quotient, remainder, A, Q, M, count=0.
//  States: IDLE, RUN, DONE.
//  IDLE: start=1 is accepted.
//   - divisor!=0: A<=0 (WIDTH+1 bits), Q<=dividend, M<=divisor, count<=WIDTH-1, go to RUN.
//   - divisor==0: quotient<={WIDTH{1}}, remainder<=dividend, div_by_zero<=1, go to DONE.
//  RUN, each cycle: {A,Q} shifts left by 1; T=A_shifted-{1'b0,M} (WIDTH+1 bits).
//   - T sign bit 0: A<=T and Q[0]<=1.
//   - Otherwise A keeps the shifted value (restore) and Q[0]<=0.
//   - count decrements each cycle; when count==0 on the final iteration, go to DONE.
//   - On that final iteration, quotient/remainder are written from the final Q and A[WIDTH-1:0]; div_by_zero<=0.
//  DONE: done=1 for exactly this cycle. Return to IDLE, or accept a new start directly (back-to-back).
//  busy=1 in RUN and in the cycle after an accepted start; busy=0 in IDLE and DONE.
//  Latency: start sampled at edge 0 -> done high after edge WIDTH+1 (normal case).
//   - Divide by zero: done high after edge 1.
//  start while busy=1 is ignored: no effect on operands, count or outputs.
//  dividend/divisor may change after acceptance without affecting the result.
//  Reset mid-RUN aborts the operation: outputs return to reset values and no done is issued.
//  Invariant for divisor!=0: dividend == quotient*divisor + remainder and remainder < divisor.
//  No overflow is possible for unsigned operands with divisor!=0.
// STRUCTURE
//  Shared package div_pkg:
//   - state enum/localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
//   - CNT_W = $clog2(WIDTH)
//  Sub-module csub_cell (D, Bout, X, Y, Bin, Sel): one-bit full subtractor plus restore mux.
//   - Instantiated WIDTH+1 times in a generate loop to form the trial-subtract row.
//   - Borrow out of the MSB cell is the restore select.
//  Top level contains only the FSM, counter, A/Q/M registers and result registers.
// TESTING
//  1. WIDTH=5, 23/4 -> quotient=5, remainder=3, div_by_zero=0; done exactly 6 cycles after start; one-cycle pulse.
//  2. 31/1 -> q=31, r=0; 7/9 -> q=0, r=7; 0/5 -> q=0, r=0; 31/31 -> q=1, r=0.
//  3. 13/0 -> q=31, r=13, div_by_zero=1; done 1 cycle after start; next valid divide clears div_by_zero.
//  4. start pulsed and operands changed during RUN -> ignored; original result unchanged; single done.
//  5. rst_n low at RUN cycle 3 -> busy=done=0 and outputs 0 immediately (async); the next start completes correctly.
//  6. Exhaustive 32x31 operand sweep, back-to-back starts in DONE -> each result matches the invariant; no dropped requests.

Source files
------------

// File: rtl/seq_restoring_divider_pkg.sv
// rtl/seq_restoring_divider_pkg.sv - shared types and constants for the restoring divider
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH = 5;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    // Iteration counter width for a given operand width; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - start/done request and result bundle for the divider
interface seq_restoring_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_restoring_divider_csub_cell.sv
// rtl/seq_restoring_divider_csub_cell.sv - one-bit full subtractor with restore mux
module csub_cell (
    output logic D,
    output logic Bout,
    input  logic X,
    input  logic Y,
    input  logic Bin,
    input  logic Sel
);

    logic diff;

    // X - Y - Bin; when Sel is high the trial difference is discarded and X passes through.
    always_comb begin
        diff = X ^ Y ^ Bin;
        Bout = (~X & Y) | (~(X ^ Y) & Bin);
        D    = Sel ? X : diff;
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative radix-2 restoring divider, one quotient bit per clock
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seq_restoring_divider_if.slave  bus
);

    localparam int CW = cnt_w(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   row_out;
    logic             restore;
    logic             unused_a_msb;

    // Partial remainder shifted left with the next dividend bit brought in from Q.
    assign a_sh  = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign m_ext = {1'b0, m_q};

    // Trial-subtract row: borrow ripples LSB to MSB, MSB borrow selects restore in every cell.
    for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
        logic bin;
        logic bout;
        if (i == 0) begin : g_lsb
            assign bin = 1'b0;
        end else begin : g_chain
            assign bin = g_cell[i-1].bout;
        end
        csub_cell u_cell (
            .D    (row_out[i]),
            .Bout (bout),
            .X    (a_sh[i]),
            .Y    (m_ext[i]),
            .Bin  (bin),
            .Sel  (restore)
        );
    end

    assign restore = g_cell[WIDTH].bout;

    // The restored remainder is always below M, so the stored MSB only mirrors the row width.
    assign unused_a_msb = a_q[WIDTH];

    // Next-state, datapath and result update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        count_d     = count_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        a_d     = '0;
                        q_d     = bus.dividend;
                        m_d     = bus.divisor;
                        count_d = CW'(WIDTH - 1);
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                a_d = row_out;
                q_d = {q_q[WIDTH-2:0], ~restore};
                if (count_q == '0) begin
                    quotient_d  = {q_q[WIDTH-2:0], ~restore};
                    remainder_d = row_out[WIDTH-1:0];
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    count_d = count_q - CW'(1);
                    busy_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All state and registered outputs; asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;

    localparam int W = 5;

    typedef struct {
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one request at a negedge and return at the negedge where done is seen.
    task automatic run_div(input logic [W-1:0] dd, input logic [W-1:0] dv, output int lat);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.start = 1'b0;
        end while (!bus.done && lat < 20);
    endtask

    initial begin
        vec_t vecs[7];
        int   lat;
        int   ndone;
        int   done_at;
        logic [W-1:0] cap_q, cap_r;
        logic         cap_z;

        vecs[0] = '{dd: 5'd23, dv: 5'd4,  q: 5'd5,  r: 5'd3,  z: 1'b0, lat: 6};
        vecs[1] = '{dd: 5'd31, dv: 5'd1,  q: 5'd31, r: 5'd0,  z: 1'b0, lat: 6};
        vecs[2] = '{dd: 5'd7,  dv: 5'd9,  q: 5'd0,  r: 5'd7,  z: 1'b0, lat: 6};
        vecs[3] = '{dd: 5'd0,  dv: 5'd5,  q: 5'd0,  r: 5'd0,  z: 1'b0, lat: 6};
        vecs[4] = '{dd: 5'd31, dv: 5'd31, q: 5'd1,  r: 5'd0,  z: 1'b0, lat: 6};
        vecs[5] = '{dd: 5'd13, dv: 5'd0,  q: 5'd31, r: 5'd13, z: 1'b1, lat: 1};
        vecs[6] = '{dd: 5'd20, dv: 5'd3,  q: 5'd6,  r: 5'd2,  z: 1'b0, lat: 6};

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_quotient", 32'(bus.quotient), 0);
        chk("reset_remainder", 32'(bus.remainder), 0);
        chk("reset_dbz", 32'(bus.div_by_zero), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_div(vecs[i].dd, vecs[i].dv, lat);
            chk($sformatf("vec%0d_quotient", i), 32'(bus.quotient), 32'(vecs[i].q));
            chk($sformatf("vec%0d_remainder", i), 32'(bus.remainder), 32'(vecs[i].r));
            chk($sformatf("vec%0d_dbz", i), 32'(bus.div_by_zero), 32'(vecs[i].z));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            @(negedge clk);
            chk($sformatf("vec%0d_pulse", i), 32'(bus.done), 0);
            chk($sformatf("vec%0d_result_hold", i), 32'(bus.quotient), 32'(vecs[i].q));
        end

        // Start pulses and operand changes while running must be ignored.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 5'd23;
        bus.divisor  = 5'd4;
        ndone   = 0;
        done_at = 0;
        cap_q   = '0;
        cap_r   = '0;
        cap_z   = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                done_at = c;
                cap_q   = bus.quotient;
                cap_r   = bus.remainder;
                cap_z   = bus.div_by_zero;
            end
            if (c == 1) bus.start = 1'b0;
            if (c == 2) begin
                bus.start    = 1'b1;
                bus.dividend = 5'd9;
                bus.divisor  = 5'd2;
            end
            if (c == 3) begin
                bus.start    = 1'b0;
                bus.dividend = 5'd1;
                bus.divisor  = 5'd0;
            end
        end
        chk("ignore_done_count", 32'(ndone), 1);
        chk("ignore_latency", 32'(done_at), 6);
        chk("ignore_quotient", 32'(cap_q), 5);
        chk("ignore_remainder", 32'(cap_r), 3);
        chk("ignore_dbz", 32'(cap_z), 0);

        // Asynchronous reset in the third RUN cycle aborts the operation.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 5'd30;
        bus.divisor  = 5'd7;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("abort_busy_before", 32'(bus.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_quotient", 32'(bus.quotient), 0);
        chk("abort_remainder", 32'(bus.remainder), 0);
        chk("abort_dbz", 32'(bus.div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 0);
        run_div(5'd26, 5'd7, lat);
        chk("after_abort_quotient", 32'(bus.quotient), 3);
        chk("after_abort_remainder", 32'(bus.remainder), 5);
        chk("after_abort_latency", 32'(lat), 6);

        // Exhaustive sweep with start held high so each DONE accepts the next request.
        @(negedge clk);
        bus.start = 1'b1;
        for (int dd = 0; dd < 32; dd++) begin
            for (int dv = 1; dv < 32; dv++) begin
                bus.dividend = W'(dd);
                bus.divisor  = W'(dv);
                lat = 0;
                do begin
                    @(posedge clk);
                    lat++;
                    @(negedge clk);
                end while (!bus.done && lat < 20);
                chk($sformatf("sweep_%0d_%0d_quotient", dd, dv), 32'(bus.quotient), 32'(dd / dv));
                chk($sformatf("sweep_%0d_%0d_remainder", dd, dv), 32'(bus.remainder), 32'(dd % dv));
                chk($sformatf("sweep_%0d_%0d_invariant", dd, dv),
                    32'(int'(bus.quotient) * dv + int'(bus.remainder)), 32'(dd));
                chk($sformatf("sweep_%0d_%0d_latency", dd, dv), 32'(lat), 6);
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("final_idle_busy", 32'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
